// File: rtl/sine_dds_multi_if.sv
// Control/sample bus for sine_dds_multi: master supplies tuning and offsets,
// slave returns packed per-channel samples, valid tag and accumulator.
interface sine_dds_multi_if #(
    parameter int CHANNELS   = 2,
    parameter int SINE_SIZE  = 13,
    parameter int ACC_WIDTH  = 24,
    parameter int PHASE_SIZE = 8
);
    logic                           enable;
    logic                           sync_clear;
    logic [ACC_WIDTH-1:0]           freq_word;
    logic [CHANNELS*PHASE_SIZE-1:0] phase_offset;
    logic [CHANNELS*SINE_SIZE-1:0]  sine;
    logic [CHANNELS*SINE_SIZE-1:0]  cosine;
    logic                           valid;
    logic [ACC_WIDTH-1:0]           phase_acc;

    modport master (output enable, sync_clear, freq_word, phase_offset,
                    input  sine, cosine, valid, phase_acc);
    modport slave  (input  enable, sync_clear, freq_word, phase_offset,
                    output sine, cosine, valid, phase_acc);
endinterface

// File: rtl/sine_dds_multi.sv
// Multi-channel DDS: one shared phase accumulator, per-channel signed offsets,
// quarter-wave LUT. Define SINE_DDS_QUADRATURE_EN to also produce cosine outputs.
module sine_dds_multi #(
    parameter int CHANNELS   = 2,
    parameter int SINE_SIZE  = 13,
    parameter int LUT_ADDR   = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int PHASE_SIZE = 8
) (
    input  logic            clock,
    input  logic            reset,
    sine_dds_multi_if.slave bus
);
    localparam int  LUT_N   = 1 << LUT_ADDR;
    localparam int  MAG_W   = SINE_SIZE - 1;
    localparam int  SHIFT   = ACC_WIDTH - PHASE_SIZE;
    localparam int  TOP     = LUT_ADDR + 2;
    localparam real HALF_PI = 1.5707963267948966;

    // Half-LSB sample points keep the quarter-wave mirror free of duplicate peak/zero.
    function automatic logic [MAG_W-1:0] lut_entry(input int k);
        real x, term, sum;
        x    = HALF_PI * (real'(k) + 0.5) / real'(LUT_N);
        term = x;
        sum  = 0.0;
        for (int n = 0; n < 12; n++) begin
            sum  = sum + term;
            term = -term * x * x / real'((2*n+2) * (2*n+3));
        end
        return MAG_W'($rtoi(real'((1 << MAG_W) - 1) * sum + 0.5));
    endfunction

    logic [MAG_W-1:0] lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = lut_entry(k);
    end

    logic [ACC_WIDTH-1:0]               acc_d, acc_q;
    logic [2:1]                         vld_pipe_d, vld_pipe_q;
    logic [CHANNELS-1:0][LUT_ADDR-1:0]  addr_d, addr_q;
    logic [CHANNELS-1:0]                neg_d, neg_q;
    logic [CHANNELS-1:0][SINE_SIZE-1:0] sine_d, sine_q;

    always_comb begin
        acc_d = acc_q;
        if (bus.sync_clear)  acc_d = '0;
        else if (bus.enable) acc_d = acc_q + bus.freq_word;
        vld_pipe_d = {vld_pipe_q[1], bus.enable};
    end

`ifdef SINE_DDS_QUADRATURE_EN
    logic [CHANNELS-1:0][LUT_ADDR-1:0]  caddr_d, caddr_q;
    logic [CHANNELS-1:0]                cneg_d, cneg_q;
    logic [CHANNELS-1:0][SINE_SIZE-1:0] cos_d, cos_q;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PHASE_SIZE-1:0] off;
        logic [1:0]            q;
        logic [LUT_ADDR-1:0]   idx;
        logic [SINE_SIZE-1:0]  mag;

        // Offset lands in the top bits; only quadrant + index survive, the rest truncates.
        assign off       = bus.phase_offset[c*PHASE_SIZE +: PHASE_SIZE];
        assign {q, idx}  = TOP'((acc_q + (ACC_WIDTH'(off) << SHIFT)) >> (ACC_WIDTH - TOP));
        assign addr_d[c] = q[0] ? ~idx : idx;
        assign neg_d[c]  = q[1];
        assign mag       = SINE_SIZE'(lut[addr_q[c]]);
        assign sine_d[c] = neg_q[c] ? -mag : mag;

`ifdef SINE_DDS_QUADRATURE_EN
        logic [1:0]           qc;
        logic [SINE_SIZE-1:0] cmag;
        assign qc         = q + 2'd1;
        assign caddr_d[c] = qc[0] ? ~idx : idx;
        assign cneg_d[c]  = qc[1];
        assign cmag       = SINE_SIZE'(lut[caddr_q[c]]);
        assign cos_d[c]   = cneg_q[c] ? -cmag : cmag;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            vld_pipe_q <= '0;
            addr_q     <= '0;
            neg_q      <= '0;
            sine_q     <= '0;
        end else begin
            acc_q      <= acc_d;
            vld_pipe_q <= vld_pipe_d;
            addr_q     <= addr_d;
            neg_q      <= neg_d;
            sine_q     <= sine_d;
        end
    end

`ifdef SINE_DDS_QUADRATURE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            caddr_q <= '0;
            cneg_q  <= '0;
            cos_q   <= '0;
        end else begin
            caddr_q <= caddr_d;
            cneg_q  <= cneg_d;
            cos_q   <= cos_d;
        end
    end
    assign bus.cosine = cos_q;
`else
    assign bus.cosine = '0;
`endif

    assign bus.sine      = sine_q;
    assign bus.valid     = vld_pipe_q[2];
    assign bus.phase_acc = acc_q;
endmodule

// File: tb/tb_sine_dds_multi.sv
// Directed bench for sine_dds_multi: constant-phase vector table, then sweep,
// enable hold, sync clear and asynchronous reset sequences.
module tb_sine_dds_multi;
    localparam int CH = 2, SS = 13, LA = 8, AW = 24, PS = 8;
`ifdef SINE_DDS_QUADRATURE_EN
    localparam bit QUAD = 1'b1;
`else
    localparam bit QUAD = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sine_dds_multi_if #(.CHANNELS(CH), .SINE_SIZE(SS), .ACC_WIDTH(AW), .PHASE_SIZE(PS)) bus ();

    sine_dds_multi #(.CHANNELS(CH), .SINE_SIZE(SS), .LUT_ADDR(LA), .ACC_WIDTH(AW),
                     .PHASE_SIZE(PS)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [PS-1:0] off0, off1;
        int            s0, s1, c0, c1;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_err = 0;
    int   s[0:299];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int sin_ch(input int c);
        logic [SS-1:0] v;
        v = bus.sine[c*SS +: SS];
        return int'($signed(v));
    endfunction

    function automatic int cos_ch(input int c);
        logic [SS-1:0] v;
        v = bus.cosine[c*SS +: SS];
        return int'($signed(v));
    endfunction

    function automatic int qexp(input int v);
        return QUAD ? v : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int a0, rep, mx, mn, nzero, nper, nanti;

        // off0, off1, sine0, sine1, cos0, cos1 at acc = 0
        vecs[0] = '{8'h00, 8'h40,   13,  4095,  4095,  -13};
        vecs[1] = '{8'h80, 8'hC0,  -13, -4095, -4095,   13};
        vecs[2] = '{8'h20, 8'h01, 2904,   113,  2887, 4093};
        vecs[3] = '{8'h7F, 8'hFF,   88,   -88, -4094, 4094};

        bus.enable       = 1'b1;
        bus.sync_clear   = 1'b0;
        bus.freq_word    = '0;
        bus.phase_offset = {vecs[0].off1, vecs[0].off0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_sine",   longint'(bus.sine), 0);
        chk("rst_cosine", longint'(bus.cosine), 0);
        chk("rst_valid",  longint'(bus.valid), 0);
        chk("rst_acc",    longint'(bus.phase_acc), 0);

        reset = 1'b1;
        tick();
        chk("valid_lat1", longint'(bus.valid), 0);

        for (int i = 0; i < 4; i++) begin
            bus.phase_offset = {vecs[i].off1, vecs[i].off0};
            repeat (2) tick();
            chk($sformatf("v%0d_sine0", i), sin_ch(0), vecs[i].s0);
            chk($sformatf("v%0d_sine1", i), sin_ch(1), vecs[i].s1);
            chk($sformatf("v%0d_cos0", i),  cos_ch(0), qexp(vecs[i].c0));
            chk($sformatf("v%0d_cos1", i),  cos_ch(1), qexp(vecs[i].c1));
            chk($sformatf("v%0d_valid", i), longint'(bus.valid), 1);
            tick();
            chk($sformatf("v%0d_hold", i),  sin_ch(0), vecs[i].s0);
            chk($sformatf("v%0d_acc", i),   longint'(bus.phase_acc), 0);
        end

        // Sweep: 256 samples per period
        bus.phase_offset = {8'h40, 8'h00};
        bus.freq_word    = 24'h010000;
        bus.sync_clear   = 1'b1;
        tick();
        bus.sync_clear = 1'b0;
        chk("sweep_clr_acc", longint'(bus.phase_acc), 0);
        for (int j = 1; j <= 292; j++) begin
            tick();
            if (j == 255) chk("acc_pre_wrap", longint'(bus.phase_acc), 24'hFF0000);
            if (j == 256) chk("acc_wrap", longint'(bus.phase_acc), 0);
            if (j >= 2) s[j-2] = sin_ch(0);
        end
        chk("sweep_s0",   s[0],   13);
        chk("sweep_s1",   s[1],   113);
        chk("sweep_s64",  s[64],  4095);
        chk("sweep_s128", s[128], -13);
        chk("sweep_s192", s[192], -4095);
        mx = -100000; mn = 100000; nzero = 0; nper = 0; nanti = 0;
        for (int j = 0; j < 256; j++) begin
            if (s[j] > mx) mx = s[j];
            if (s[j] < mn) mn = s[j];
            if (s[j] == 0) nzero++;
        end
        for (int j = 0; j < 35; j++)  if (s[j] != s[j+256]) nper++;
        for (int j = 0; j < 162; j++) if (s[j+128] != -s[j]) nanti++;
        chk("sweep_peak",     mx, 4095);
        chk("sweep_trough",   mn, -4095);
        chk("sweep_zeros",    nzero, 0);
        chk("sweep_period",   nper, 0);
        chk("sweep_antisym",  nanti, 0);

        // Enable low for one cycle
        a0 = int'(bus.phase_acc);
        bus.enable = 1'b0;
        tick();
        chk("en_hold_acc",   longint'(bus.phase_acc), a0);
        chk("en_valid_n1",   longint'(bus.valid), 1);
        bus.enable = 1'b1;
        tick();
        chk("en_resume_acc", longint'(bus.phase_acc), (a0 + 24'h010000) & 24'hFFFFFF);
        chk("en_valid_n2",   longint'(bus.valid), 0);
        rep = sin_ch(0);
        tick();
        chk("en_valid_n3",   longint'(bus.valid), 1);
        chk("en_sample_rep", sin_ch(0), rep);

        // sync_clear mid-run with enable high
        bus.sync_clear = 1'b1;
        tick();
        chk("clr_acc", longint'(bus.phase_acc), 0);
        bus.sync_clear = 1'b0;
        tick();
        chk("clr_acc_next", longint'(bus.phase_acc), 24'h010000);
        tick();
        chk("clr_sine0", sin_ch(0), 13);
        chk("clr_sine1", sin_ch(1), 4095);
        chk("clr_cos0",  cos_ch(0), qexp(4095));
        chk("clr_valid", longint'(bus.valid), 1);

        // Asynchronous reset between edges
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_sine",   longint'(bus.sine), 0);
        chk("arst_cosine", longint'(bus.cosine), 0);
        chk("arst_valid",  longint'(bus.valid), 0);
        chk("arst_acc",    longint'(bus.phase_acc), 0);
        #10 reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
